// File: rtl/cdb_arbiter_if.sv
// ---------------------------------------------------------------------------
// cdb_arbiter_if
// Bundle of the request/grant signals between the functional-unit output
// buffers and the common-data-bus arbiter.
//
// Signals:
//   request      : bit i = not_empty of output buffer i
//   bus_stall    : CDB consumers cannot accept a broadcast this cycle
//   permit       : one-hot (or zero) data_bus_permit, combinational
//   bus_valid    : CDB carries a valid broadcast this cycle
//   grant_idx    : index of the set permit bit, 0 when idle
//   rr_ptr       : current round-robin priority pointer (debug)
//   grant_count  : grants since reset, wraps at 2^16
//   starve_alarm : sticky starvation diagnostic
//
// Modports:
//   master : the buffer side (drives request/bus_stall)
//   slave  : the arbiter side (drives grants and status)
// ---------------------------------------------------------------------------
interface cdb_arbiter_if #(
  parameter int N_REQ     = 4,
  parameter int IDX_WIDTH = $clog2(N_REQ)
) ();
  logic [N_REQ-1:0]     request;
  logic                 bus_stall;
  logic [N_REQ-1:0]     permit;
  logic                 bus_valid;
  logic [IDX_WIDTH-1:0] grant_idx;
  logic [IDX_WIDTH-1:0] rr_ptr;
  logic [15:0]          grant_count;
  logic                 starve_alarm;

  modport master (
    output request, bus_stall,
    input  permit, bus_valid, grant_idx, rr_ptr, grant_count, starve_alarm
  );

  modport slave (
    input  request, bus_stall,
    output permit, bus_valid, grant_idx, rr_ptr, grant_count, starve_alarm
  );
endinterface

// File: rtl/cdb_arbiter.sv
// ---------------------------------------------------------------------------
// cdb_arbiter
// Round-robin arbiter for the common data bus. Each functional-unit output
// buffer raises its not_empty flag on request[i]; the arbiter returns a
// combinational one-hot permit so exactly one buffer drives the CDB in the
// same cycle. The buffer pops on the next rising edge and the priority
// pointer moves to one past the winner on that same edge.
//
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high; also forces permit to zero at once
//   bus   : cdb_arbiter_if.slave (request, bus_stall in; permit, bus_valid,
//           grant_idx, rr_ptr, grant_count, starve_alarm out)
//
// Optional feature (macro CDB_ARB_STARVE_MON_EN):
//   Defined   : per-requester saturating wait counters drive a sticky
//               starve_alarm once any requester has waited STARVE_LIMIT
//               cycles. Diagnostic only, grant selection is unaffected.
//   Undefined : no counters; starve_alarm is constant 0.
// ---------------------------------------------------------------------------
module cdb_arbiter #(
  parameter int N_REQ        = 4,
  parameter int IDX_WIDTH    = $clog2(N_REQ),
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_WIDTH    = 4
) (
  input  logic         clk,
  input  logic         reset,
  cdb_arbiter_if.slave bus
);

  // Elaboration-time legality checks on the configuration.
  if ((N_REQ < 2) || (N_REQ > 16)) begin : g_bad_nreq
    $error("cdb_arbiter: N_REQ must be within 2..16");
  end
  if (((2 ** CNT_WIDTH) - 1) < STARVE_LIMIT) begin : g_bad_cnt
    $error("cdb_arbiter: CNT_WIDTH too narrow for STARVE_LIMIT");
  end

  // One extra bit so ptr + offset never overflows before the wrap compare.
  localparam logic [IDX_WIDTH:0]   N_REQ_W  = (IDX_WIDTH + 1)'(N_REQ);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(N_REQ - 1);

  logic [IDX_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [15:0]          grant_count_q, grant_count_d;
  logic                 starve_alarm_q, starve_alarm_d;

  logic [N_REQ-1:0]     permit_s;
  logic [IDX_WIDTH-1:0] grant_idx_s;
  logic                 bus_valid_s;
  logic                 found_s;
  logic [IDX_WIDTH:0]   sum_s;
  logic [IDX_WIDTH-1:0] cand_s;

  // Rotating priority scan starting at rr_ptr; reset and stall force idle.
  always_comb begin
    permit_s    = '0;
    grant_idx_s = '0;
    found_s     = 1'b0;
    sum_s       = '0;
    cand_s      = '0;
    if (!reset && !bus.bus_stall) begin
      for (int off = 0; off < N_REQ; off++) begin
        sum_s = {1'b0, rr_ptr_q} + (IDX_WIDTH + 1)'(off);
        // Explicit wrap keeps non-power-of-2 N_REQ correct.
        if (sum_s >= N_REQ_W) begin
          sum_s = sum_s - N_REQ_W;
        end else begin
          sum_s = sum_s;
        end
        cand_s = sum_s[IDX_WIDTH-1:0];
        if (!found_s && bus.request[cand_s]) begin
          found_s          = 1'b1;
          permit_s[cand_s] = 1'b1;
          grant_idx_s      = cand_s;
        end else begin
          found_s = found_s;
        end
      end
    end else begin
      permit_s = '0;
    end
  end

  assign bus_valid_s = |permit_s;

  // Next pointer and grant counter; both move only on a granted cycle.
  always_comb begin
    rr_ptr_d      = rr_ptr_q;
    grant_count_d = grant_count_q;
    if (bus_valid_s) begin
      rr_ptr_d      = (grant_idx_s == LAST_IDX) ? '0 : (grant_idx_s + IDX_WIDTH'(1));
      grant_count_d = grant_count_q + 16'd1;
    end else begin
      rr_ptr_d      = rr_ptr_q;
      grant_count_d = grant_count_q;
    end
  end

`ifdef CDB_ARB_STARVE_MON_EN
  localparam logic [CNT_WIDTH-1:0] STARVE_LIMIT_W = CNT_WIDTH'(STARVE_LIMIT);

  logic [CNT_WIDTH-1:0] wc_q [N_REQ];
  logic [CNT_WIDTH-1:0] wc_d [N_REQ];

  // Wait counters count cycles spent requesting without a permit; stalls count too.
  always_comb begin
    starve_alarm_d = starve_alarm_q;
    for (int i = 0; i < N_REQ; i++) begin
      wc_d[i] = '0;
      if (bus.request[i] && !permit_s[i]) begin
        if (wc_q[i] != {CNT_WIDTH{1'b1}}) begin
          wc_d[i] = wc_q[i] + CNT_WIDTH'(1);
        end else begin
          wc_d[i] = wc_q[i];
        end
      end else begin
        wc_d[i] = '0;
      end
      if (wc_d[i] >= STARVE_LIMIT_W) begin
        starve_alarm_d = 1'b1;
      end else begin
        starve_alarm_d = starve_alarm_d;
      end
    end
  end

  // Wait-counter state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wc_q <= '{default: '0};
    end else begin
      wc_q <= wc_d;
    end
  end
`else
  // Monitor absent: alarm stays low.
  always_comb begin
    starve_alarm_d = 1'b0;
  end
`endif

  // Architectural state: pointer, grant counter, sticky alarm.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q       <= '0;
      grant_count_q  <= 16'd0;
      starve_alarm_q <= 1'b0;
    end else begin
      rr_ptr_q       <= rr_ptr_d;
      grant_count_q  <= grant_count_d;
      starve_alarm_q <= starve_alarm_d;
    end
  end

  assign bus.permit       = permit_s;
  assign bus.bus_valid    = bus_valid_s;
  assign bus.grant_idx    = grant_idx_s;
  assign bus.rr_ptr       = rr_ptr_q;
  assign bus.grant_count  = grant_count_q;
  assign bus.starve_alarm = starve_alarm_q;

endmodule
